wr_ht_budget_store: RTL and testbench
=====================================

Name: wr_ht_budget_store

Overview:
- Storage and bookkeeping slice of the write-transaction guard.
- Holds the registered head-tail (HT) table, which maps each AXI ID to head/tail indices in the linked-data table.
- Derives the HT free vector, the first-free index and a full flag.
- Computes the accumulated outstanding burst budget from the linked-data counters. Sits between the write transaction manager (next-state producer) and the ID lookup/allocation logic.

Parameters:
- HtCapacity, 8, number of HT entries (>=1)
- MaxTxns, 8, number of linked-data entries (>=1)
- IdWidth, 4, AXI ID width
- CntWidth, 8, per-transaction counter width; accumulated width AccuW = CntWidth+1
- LdIdxWidth, derived: max(1, clog2(MaxTxns)); not overridable
- HtIdxWidth, derived: max(1, clog2(HtCapacity)); not overridable
- EntryW, derived: IdWidth + 2*LdIdxWidth + 1

Ports:
- clk_i  in  1  clock; one clock domain
- rst_i  in  1  asynchronous, active-high reset
- ht_d_i  in  HtCapacity*EntryW  next-state HT table; entry i occupies bits [i*EntryW +: EntryW]
- ht_q_o  out  HtCapacity*EntryW  registered HT table, same packing
- ht_free_o  out  HtCapacity  bit i = free flag of registered entry i
- ht_free_idx_o  out  HtIdxWidth  lowest index with ht_free_o set
- ht_full_o  out  1  no free HT entry
- ld_counter_i  in  MaxTxns*AccuW  linked-data counter of entry j at [j*AccuW +: AccuW]
- ld_free_i  in  MaxTxns  bit j = linked-data entry j is free
- accum_burst_len_o  out  AccuW  summed counters of occupied linked-data entries

Behaviour:
- Entry layout, MSB to LSB: id[IdWidth], head[LdIdxWidth], tail[LdIdxWidth], free[1]. Free is bit 0 of each entry.
- HT registers:
  - Every rising clk_i edge, each entry q <= d unconditionally; there is no enable.
  - Latency from ht_d_i to ht_q_o is one cycle.
- Reset:
  - Asserting rst_i immediately (asynchronously) forces every entry to id=0, head=0, tail=0, free=1. It holds there while rst_i is high.
  - The first capture occurs on the first clk_i edge after deassertion.
  - Reset values of the outputs: ht_q_o = all entries with only the free bit set; ht_free_o = all ones; ht_free_idx_o = 0; ht_full_o = 0. accum_burst_len_o depends only on its inputs.
- Free vector: ht_free_o[i] = ht_q_o entry i free bit. It is purely combinational from the registered state and never from ht_d_i.
- Free index:
  - Priority encoder from index 0; ht_free_idx_o = smallest i with ht_free_o[i]=1.
  - When ht_free_o == 0: ht_full_o = 1 and ht_free_idx_o = 0.
  - Otherwise ht_full_o = 0.
- Budget:
  - accum_burst_len_o = sum over j of ld_counter_i[j] where ld_free_i[j]=0. Free entries contribute 0 regardless of their counter value.
  - Purely combinational, zero latency.
  - Arithmetic uses an internal sum at least AccuW+clog2(MaxTxns) bits wide. The result saturates at 2^AccuW-1 and never wraps.
  - All entries free -> 0.
- A simultaneous reset and clock edge: reset wins.
- No X propagation from free entries' id/head/tail into any output except ht_q_o.

Test Plan:
- Reset: assert rst_i mid-run with nonzero table -> ht_q_o entries drop to 0x..1 pattern immediately (no clock), ht_free_o=all ones, ht_free_idx_o=0, ht_full_o=0.
- Latency: drive entry 2 = {id=5, head=3, tail=4, free=0} on ht_d_i, others free -> ht_q_o reflects it exactly one edge later; ht_free_o=8'b1111_1011; ht_free_idx_o=0.
- Free index: occupy entries 0,1,2 (free=0) -> ht_free_idx_o=3. Occupy all 8 -> ht_full_o=1, ht_free_idx_o=0. Free entry 7 -> ht_full_o=0, idx=7 one cycle later.
- Budget masking: counters {10, 20, 30, 40, 0...}, ld_free_i=8'b1111_0100 -> accum_burst_len_o=10+20+40=70 same cycle. All free -> 0.
- Saturation: all 8 entries occupied with counter 200 (AccuW=9) -> accum_burst_len_o=511, not 1600 mod 512.
- Back-to-back updates: change ht_d_i every cycle for 4 cycles -> ht_q_o follows with a one-cycle lag each cycle, no dropped values.

Source files
------------

// File: rtl/wr_ht_budget_store.sv
// Head-tail table storage for the write-transaction guard: registered HT entries,
// free vector / first-free index / full flag, and the saturating outstanding burst budget.
module wr_ht_budget_store #(
  parameter int HtCapacity = 8,
  parameter int MaxTxns    = 8,
  parameter int IdWidth    = 4,
  parameter int CntWidth   = 8,
  localparam int AccuW      = CntWidth + 1,
  localparam int LdIdxWidth = (MaxTxns > 1) ? $clog2(MaxTxns) : 1,
  localparam int HtIdxWidth = (HtCapacity > 1) ? $clog2(HtCapacity) : 1,
  localparam int EntryW     = IdWidth + 2 * LdIdxWidth + 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [HtCapacity*EntryW-1:0] ht_d_i,
  output logic [HtCapacity*EntryW-1:0] ht_q_o,
  output logic [HtCapacity-1:0]        ht_free_o,
  output logic [HtIdxWidth-1:0]        ht_free_idx_o,
  output logic                         ht_full_o,
  input  logic [MaxTxns*AccuW-1:0]     ld_counter_i,
  input  logic [MaxTxns-1:0]           ld_free_i,
  output logic [AccuW-1:0]             accum_burst_len_o
);

  // The sum holds MaxTxns full-scale counters without wrapping before saturation.
  localparam int SumW = AccuW + LdIdxWidth;
  localparam logic [AccuW-1:0] AccuMax = '1;

  logic [HtCapacity*EntryW-1:0] ht_q;
  logic [HtCapacity-1:0]        ht_free;
  logic [HtIdxWidth-1:0]        ht_free_idx;
  logic [SumW-1:0]              sum;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < HtCapacity; i++) begin
        ht_q[i*EntryW +: EntryW] <= EntryW'(1);
      end
    end else begin
      ht_q <= ht_d_i;
    end
  end

  // Only the free bit of each registered entry feeds the status outputs.
  always_comb begin
    ht_free = '0;
    for (int i = 0; i < HtCapacity; i++) begin
      ht_free[i] = ht_q[i*EntryW];
    end
  end

  // Scanning downwards leaves the lowest free index as the final assignment.
  always_comb begin
    ht_free_idx = '0;
    for (int i = HtCapacity - 1; i >= 0; i--) begin
      if (ht_free[i]) begin
        ht_free_idx = HtIdxWidth'(i);
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int j = 0; j < MaxTxns; j++) begin
      if (!ld_free_i[j]) begin
        sum = sum + SumW'(ld_counter_i[j*AccuW +: AccuW]);
      end
    end
  end

  assign ht_q_o            = ht_q;
  assign ht_free_o         = ht_free;
  assign ht_free_idx_o     = ht_free_idx;
  assign ht_full_o         = ~|ht_free;
  assign accum_burst_len_o = (sum > SumW'(AccuMax)) ? AccuMax : sum[AccuW-1:0];

endmodule

// File: tb/tb_wr_ht_budget_store.sv
// Self-checking bench for wr_ht_budget_store: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_wr_ht_budget_store;

  localparam int HT = 8;
  localparam int MT = 8;
  localparam int IW = 4;
  localparam int CW = 8;
  localparam int AW = CW + 1;
  localparam int LW = 3;
  localparam int HW = 3;
  localparam int EW = IW + 2 * LW + 1;
  localparam int AMAX = (1 << AW) - 1;

  logic                 clk;
  logic                 rst;
  logic [HT*EW-1:0]     ht_d;
  logic [HT*EW-1:0]     ht_q;
  logic [HT-1:0]        ht_free;
  logic [HW-1:0]        ht_free_idx;
  logic                 ht_full;
  logic [MT*AW-1:0]     ld_counter;
  logic [MT-1:0]        ld_free;
  logic [AW-1:0]        accum;

  int n_checks;
  int n_fail;

  // Reference model: driven next-state entries (d_*) and expected registered entries (q_*).
  int d_id[HT], d_head[HT], d_tail[HT], d_free[HT];
  int q_id[HT], q_head[HT], q_tail[HT], q_free[HT];
  int cnt[MT];
  int lfree[MT];

  wr_ht_budget_store dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .ht_d_i            (ht_d),
    .ht_q_o            (ht_q),
    .ht_free_o         (ht_free),
    .ht_free_idx_o     (ht_free_idx),
    .ht_full_o         (ht_full),
    .ld_counter_i      (ld_counter),
    .ld_free_i         (ld_free),
    .accum_burst_len_o (accum)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [HT*EW-1:0] pack_d();
    logic [HT*EW-1:0] v;
    for (int i = 0; i < HT; i++)
      v[i*EW +: EW] = {IW'(d_id[i]), LW'(d_head[i]), LW'(d_tail[i]), d_free[i] != 0};
    return v;
  endfunction

  function automatic logic [HT*EW-1:0] pack_q();
    logic [HT*EW-1:0] v;
    for (int i = 0; i < HT; i++)
      v[i*EW +: EW] = {IW'(q_id[i]), LW'(q_head[i]), LW'(q_tail[i]), q_free[i] != 0};
    return v;
  endfunction

  function automatic logic [HT-1:0] exp_free();
    logic [HT-1:0] v;
    for (int i = 0; i < HT; i++) v[i] = (q_free[i] != 0);
    return v;
  endfunction

  function automatic int exp_idx();
    for (int i = 0; i < HT; i++) if (q_free[i] != 0) return i;
    return 0;
  endfunction

  function automatic logic exp_full();
    for (int i = 0; i < HT; i++) if (q_free[i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int exp_accum();
    int s;
    s = 0;
    for (int j = 0; j < MT; j++) if (lfree[j] == 0) s += cnt[j];
    return (s > AMAX) ? AMAX : s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < HT; i++) begin
      q_id[i] = 0; q_head[i] = 0; q_tail[i] = 0; q_free[i] = 1;
    end
  endtask

  task automatic set_all_free_d();
    for (int i = 0; i < HT; i++) begin
      d_id[i] = 0; d_head[i] = 0; d_tail[i] = 0; d_free[i] = 1;
    end
    ht_d = pack_d();
  endtask

  task automatic drive_ld();
    for (int j = 0; j < MT; j++) begin
      ld_counter[j*AW +: AW] = AW'(cnt[j]);
      ld_free[j] = (lfree[j] != 0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) begin
      q_id = d_id; q_head = d_head; q_tail = d_tail; q_free = d_free;
    end
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (ht_q !== pack_q()) begin n_fail++; $display("FAIL reset_init ht_q got %h exp %h", ht_q, pack_q()); end
    n_checks++;
    if (ht_free !== 8'hFF || ht_free_idx !== 3'd0 || ht_full !== 1'b0) begin
      n_fail++; $display("FAIL reset_init_status free %b idx %0d full %b exp ff/0/0", ht_free, ht_free_idx, ht_full);
    end
    for (int i = 0; i < HT; i++) begin
      d_id[i] = i + 1; d_head[i] = i % 8; d_tail[i] = 7 - i; d_free[i] = 0;
    end
    ht_d = pack_d();
    step();
    n_checks++;
    if (ht_q !== pack_q()) begin n_fail++; $display("FAIL reset_hold ht_q got %h exp %h", ht_q, pack_q()); end
    rst = 1'b0;
    step();
    n_checks++;
    if (ht_q !== pack_q() || ht_full !== 1'b1) begin
      n_fail++; $display("FAIL reset_first_capture ht_q got %h exp %h full %b", ht_q, pack_q(), ht_full);
    end
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (ht_q !== pack_q()) begin n_fail++; $display("FAIL reset_async ht_q got %h exp %h", ht_q, pack_q()); end
    n_checks++;
    if (ht_free !== 8'hFF || ht_free_idx !== 3'd0 || ht_full !== 1'b0) begin
      n_fail++; $display("FAIL reset_async_status free %b idx %0d full %b exp ff/0/0", ht_free, ht_free_idx, ht_full);
    end
    step();
    n_checks++;
    if (ht_q !== pack_q()) begin n_fail++; $display("FAIL reset_wins_edge ht_q got %h exp %h", ht_q, pack_q()); end
    set_all_free_d();
    rst = 1'b0;
  endtask

  task automatic test_latency();
    set_all_free_d();
    step();
    d_id[2] = 5; d_head[2] = 3; d_tail[2] = 4; d_free[2] = 0;
    ht_d = pack_d();
    #1;
    n_checks++;
    if (ht_free !== 8'hFF) begin n_fail++; $display("FAIL latency_pre_edge free got %b exp 11111111", ht_free); end
    step();
    n_checks++;
    if (ht_q !== pack_q() || ht_q[2*EW +: EW] !== {4'd5, 3'd3, 3'd4, 1'b0}) begin
      n_fail++; $display("FAIL latency ht_q got %h exp %h", ht_q, pack_q());
    end
    n_checks++;
    if (ht_free !== 8'b1111_1011 || ht_free_idx !== 3'd0 || ht_full !== 1'b0) begin
      n_fail++; $display("FAIL latency_status free %b idx %0d full %b exp 11111011/0/0", ht_free, ht_free_idx, ht_full);
    end
  endtask

  task automatic test_free_index();
    set_all_free_d();
    for (int i = 0; i < 3; i++) begin d_free[i] = 0; d_id[i] = 9 + i; end
    ht_d = pack_d();
    step();
    n_checks++;
    if (ht_free_idx !== 3'(exp_idx()) || ht_free_idx !== 3'd3 || ht_full !== 1'b0) begin
      n_fail++; $display("FAIL free_idx_three idx %0d full %b exp 3/0", ht_free_idx, ht_full);
    end
    for (int i = 0; i < HT; i++) d_free[i] = 0;
    ht_d = pack_d();
    step();
    n_checks++;
    if (ht_full !== 1'b1 || ht_free_idx !== 3'd0 || ht_free !== 8'h00) begin
      n_fail++; $display("FAIL free_idx_full idx %0d full %b free %b exp 0/1/00000000", ht_free_idx, ht_full, ht_free);
    end
    d_free[7] = 1;
    ht_d = pack_d();
    #1;
    n_checks++;
    if (ht_full !== 1'b1) begin n_fail++; $display("FAIL free_idx_not_comb full got %b exp 1", ht_full); end
    step();
    n_checks++;
    if (ht_full !== 1'b0 || ht_free_idx !== 3'd7) begin
      n_fail++; $display("FAIL free_idx_last idx %0d full %b exp 7/0", ht_free_idx, ht_full);
    end
  endtask

  task automatic test_budget();
    for (int j = 0; j < MT; j++) begin cnt[j] = 0; lfree[j] = 1; end
    cnt[0] = 10; cnt[1] = 20; cnt[2] = 30; cnt[3] = 40;
    lfree[0] = 0; lfree[1] = 0; lfree[3] = 0;
    drive_ld();
    #1;
    n_checks++;
    if (accum !== AW'(70) || accum !== AW'(exp_accum())) begin
      n_fail++; $display("FAIL budget_mask got %0d exp 70", accum);
    end
    for (int j = 0; j < MT; j++) begin lfree[j] = 1; cnt[j] = $urandom_range(0, AMAX); end
    drive_ld();
    #1;
    n_checks++;
    if (accum !== AW'(0)) begin n_fail++; $display("FAIL budget_all_free got %0d exp 0", accum); end
  endtask

  task automatic test_saturation();
    for (int j = 0; j < MT; j++) begin cnt[j] = 200; lfree[j] = 0; end
    drive_ld();
    #1;
    n_checks++;
    if (accum !== AW'(AMAX)) begin n_fail++; $display("FAIL saturate_all got %0d exp %0d", accum, AMAX); end
    for (int j = 0; j < MT; j++) begin cnt[j] = 0; lfree[j] = 1; end
    cnt[1] = 255; cnt[4] = 256; lfree[1] = 0; lfree[4] = 0;
    drive_ld();
    #1;
    n_checks++;
    if (accum !== AW'(511)) begin n_fail++; $display("FAIL saturate_exact got %0d exp 511", accum); end
    cnt[4] = 255;
    drive_ld();
    #1;
    n_checks++;
    if (accum !== AW'(510)) begin n_fail++; $display("FAIL saturate_below got %0d exp 510", accum); end
    for (int j = 0; j < MT; j++) begin cnt[j] = AMAX; lfree[j] = 0; end
    drive_ld();
    #1;
    n_checks++;
    if (accum !== AW'(AMAX)) begin n_fail++; $display("FAIL saturate_max got %0d exp %0d", accum, AMAX); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < HT; i++) begin
        d_id[i] = (k * 3 + i) % 16; d_head[i] = (k + i) % 8; d_tail[i] = (k * 5 + i) % 8;
        d_free[i] = ((i + k) % 3 == 0) ? 1 : 0;
      end
      ht_d = pack_d();
      step();
      n_checks++;
      if (ht_q !== pack_q()) begin n_fail++; $display("FAIL back_to_back[%0d] ht_q got %h exp %h", k, ht_q, pack_q()); end
      n_checks++;
      if (ht_free !== exp_free() || ht_free_idx !== 3'(exp_idx())) begin
        n_fail++; $display("FAIL back_to_back_status[%0d] free %b idx %0d exp %b/%0d", k, ht_free, ht_free_idx, exp_free(), exp_idx());
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++) begin
      for (int i = 0; i < HT; i++) begin
        d_id[i] = $urandom_range(0, 15); d_head[i] = $urandom_range(0, 7);
        d_tail[i] = $urandom_range(0, 7); d_free[i] = ($urandom_range(0, 3) == 0) ? 1 : 0;
      end
      ht_d = pack_d();
      for (int j = 0; j < MT; j++) begin
        cnt[j] = (k % 2 == 0) ? $urandom_range(0, 80) : $urandom_range(0, AMAX);
        lfree[j] = $urandom_range(0, 1);
      end
      drive_ld();
      step();
      n_checks++;
      if (ht_q !== pack_q()) begin n_fail++; $display("FAIL random_ht_q[%0d] got %h exp %h", k, ht_q, pack_q()); end
      n_checks++;
      if (ht_free !== exp_free() || ht_free_idx !== 3'(exp_idx()) || ht_full !== exp_full()) begin
        n_fail++; $display("FAIL random_status[%0d] free %b idx %0d full %b exp %b/%0d/%b",
                           k, ht_free, ht_free_idx, ht_full, exp_free(), exp_idx(), exp_full());
      end
      n_checks++;
      if (accum !== AW'(exp_accum())) begin n_fail++; $display("FAIL random_accum[%0d] got %0d exp %0d", k, accum, exp_accum()); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    model_reset();
    set_all_free_d();
    for (int j = 0; j < MT; j++) begin cnt[j] = 0; lfree[j] = 1; end
    drive_ld();
    test_reset();
    test_latency();
    test_free_index();
    test_budget();
    test_saturation();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
